uart_rx_param: RTL and testbench

Parametrised UART receiver. It is the next generation of the single-format 8N1 receiver block. It oversamples the serial line on a sample-enable tick and takes a 3-sample majority vote at each bit centre. Data width, parity and stop-bit count are configurable. It reports framing, parity and break errors, and presents each received word with a one-cycle valid strobe. It sits between the pad input and the RX FIFO or register bank of the UART.

---
 rtl/uart_rx_param.sv | 189 ++++++++++++++++++
 tb/tb_uart_rx_param.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: oversampled start detection, 3-sample majority vote
// per bit, configurable data width, parity and stop bits, with framing/parity/break flags.
module uart_rx_param #(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int PARITY_EN   = 0,
    parameter int PARITY_ODD  = 0,
    parameter int STOP_BITS   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    input  logic                 bit_in,
    output logic [DATA_BITS-1:0] out,
    output logic                 valid,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 break_det
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] S_LO   = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] S_MID  = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] S_HI   = CW'(OVERSAMPLE / 2 + 1);
    localparam logic [CW-1:0] C_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic       ODD       = 1'(PARITY_ODD);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    logic [SYNC_STAGES-1:0] sync;
    logic                   rxs;
    state_t                 state, state_nx;
    logic [CW-1:0]          cnt, cnt_nx;
    logic [3:0]             idx, idx_nx;
    logic [DATA_BITS-1:0]   shreg, shreg_nx;
    logic [1:0]             smp, smp_nx;
    logic                   par_flag, par_nx;
    logic                   frm_flag, frm_nx;
    logic                   par_zero, pz_nx;
    logic                   vote;
    logic                   done;

    assign rxs = sync[SYNC_STAGES-1];

    // Line synchroniser; flops reset to the idle (high) level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], bit_in};
        end
    end

    // Receiver state and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            idx      <= 4'd0;
            shreg    <= '0;
            smp      <= 2'b00;
            par_flag <= 1'b0;
            frm_flag <= 1'b0;
            par_zero <= 1'b1;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            idx      <= idx_nx;
            shreg    <= shreg_nx;
            smp      <= smp_nx;
            par_flag <= par_nx;
            frm_flag <= frm_nx;
            par_zero <= pz_nx;
        end
    end

    // Next-state logic: tick counting, majority vote and per-state bit handling.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        idx_nx   = idx;
        shreg_nx = shreg;
        smp_nx   = smp;
        par_nx   = par_flag;
        frm_nx   = frm_flag;
        pz_nx    = par_zero;
        done     = 1'b0;
        vote     = (smp[0] & smp[1]) | (smp[0] & rxs) | (smp[1] & rxs);
        if (!ena) begin
            state_nx = state;
        end else if (state == IDLE) begin
            if (!rxs) begin
                // This ena is count 0, so the next one is count 1.
                state_nx = START;
                cnt_nx   = CW'(1);
                idx_nx   = 4'd0;
                par_nx   = 1'b0;
                frm_nx   = 1'b0;
                pz_nx    = 1'b1;
            end else begin
                state_nx = IDLE;
            end
        end else begin
            cnt_nx    = (cnt == C_LAST) ? '0 : cnt + CW'(1);
            smp_nx[0] = (cnt == S_LO)  ? rxs : smp[0];
            smp_nx[1] = (cnt == S_MID) ? rxs : smp[1];
            if (cnt == S_HI) begin
                case (state)
                    START: begin
                        if (vote) begin
                            state_nx = IDLE;
                        end else begin
                            state_nx = DATA;
                            idx_nx   = 4'd0;
                        end
                    end
                    DATA: begin
                        for (int i = 0; i < DATA_BITS; i++) begin
                            shreg_nx[i] = (idx == 4'(i)) ? vote : shreg[i];
                        end
                        if (idx == DATA_LAST) begin
                            idx_nx   = 4'd0;
                            state_nx = (PARITY_EN != 0) ? PARITY : STOP;
                        end else begin
                            idx_nx = idx + 4'd1;
                        end
                    end
                    PARITY: begin
                        par_nx   = (vote != ((^shreg) ^ ODD));
                        pz_nx    = ~vote;
                        state_nx = STOP;
                    end
                    STOP: begin
                        frm_nx = frm_flag | ~vote;
                        // Leave at the centre of the last stop bit so the next start edge is caught.
                        if (idx == STOP_LAST) begin
                            state_nx = IDLE;
                            done     = 1'b1;
                        end else begin
                            idx_nx = idx + 4'd1;
                        end
                    end
                    default: begin
                        state_nx = IDLE;
                    end
                endcase
            end else begin
                state_nx = state;
            end
        end
    end

    // Registered outputs: word and flags load together with the valid strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            out        <= '0;
            valid      <= 1'b0;
            busy       <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            break_det  <= 1'b0;
        end else begin
            valid <= done;
            busy  <= (state_nx != IDLE);
            if (done) begin
                out        <= shreg;
                frame_err  <= frm_nx;
                parity_err <= par_flag;
                break_det  <= frm_nx & (shreg == '0) & par_zero;
            end else begin
                out        <= out;
                frame_err  <= frame_err;
                parity_err <= parity_err;
                break_det  <= break_det;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param: three configurations (8N1, 8E1, 7N2) driven
// from per-tick waveforms and compared against a frame-level reference model.
module tb_uart_rx_param;

    localparam int OS = 16;

    typedef struct {
        logic [8:0] d;
        logic       pe;
        logic       fe;
        logic       bk;
        int         t;
    } cap_t;

    logic       clk;
    logic       rst;
    logic       ena;
    logic [2:0] lines;

    logic [7:0] out_a, out_p;
    logic [6:0] out_s;
    logic valid_a, busy_a, fe_a, pe_a, bk_a;
    logic valid_p, busy_p, fe_p, pe_p, bk_p;
    logic valid_s, busy_s, fe_s, pe_s, bk_s;

    int   checks   = 0;
    int   failures = 0;
    int   ncyc     = 0;
    int   rise_a   = -1;
    int   fall_a   = -1;
    logic busy_prev_a = 1'b0;
    cap_t qa[$], qp[$], qs[$];
    logic wave[$];

    uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_EN(0), .PARITY_ODD(0),
                    .STOP_BITS(1), .SYNC_STAGES(2)) dut_a (
        .clk(clk), .rst(rst), .ena(ena), .bit_in(lines[0]), .out(out_a), .valid(valid_a),
        .busy(busy_a), .frame_err(fe_a), .parity_err(pe_a), .break_det(bk_a));

    uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_EN(1), .PARITY_ODD(0),
                    .STOP_BITS(1), .SYNC_STAGES(2)) dut_p (
        .clk(clk), .rst(rst), .ena(ena), .bit_in(lines[1]), .out(out_p), .valid(valid_p),
        .busy(busy_p), .frame_err(fe_p), .parity_err(pe_p), .break_det(bk_p));

    uart_rx_param #(.DATA_BITS(7), .OVERSAMPLE(OS), .PARITY_EN(0), .PARITY_ODD(0),
                    .STOP_BITS(2), .SYNC_STAGES(2)) dut_s (
        .clk(clk), .rst(rst), .ena(ena), .bit_in(lines[2]), .out(out_s), .valid(valid_s),
        .busy(busy_s), .frame_err(fe_s), .parity_err(pe_s), .break_det(bk_s));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output monitor: timestamps each valid word and busy edges on the falling clock edge.
    always @(negedge clk) begin
        ncyc <= ncyc + 1;
        if (valid_a) qa.push_back('{d: 9'(out_a), pe: pe_a, fe: fe_a, bk: bk_a, t: ncyc});
        if (valid_p) qp.push_back('{d: 9'(out_p), pe: pe_p, fe: fe_p, bk: bk_p, t: ncyc});
        if (valid_s) qs.push_back('{d: 9'(out_s), pe: pe_s, fe: fe_s, bk: bk_s, t: ncyc});
        if (busy_a && !busy_prev_a) rise_a = ncyc;
        if (!busy_a && busy_prev_a) fall_a = ncyc;
        busy_prev_a = busy_a;
    end

    // Reference model: flags {parity_err, frame_err, break_det} for one frame.
    function automatic logic [2:0] model_flags(input logic [8:0] d, input int nd, input int pen,
                                               input logic pbit, input logic [1:0] stp, input int ns);
        int   ones = 0;
        logic fe = 1'b0;
        logic pe;
        for (int i = 0; i < nd; i++) ones += int'(d[i]);
        pe = (pen != 0) && (pbit != ((ones % 2) == 1));
        for (int i = 0; i < ns; i++) if (!stp[i]) fe = 1'b1;
        return {pe, fe, fe && (ones == 0) && (pen == 0 || pbit == 1'b0)};
    endfunction

    // Valid is seen (nbits-1)*OS + 9 ticks after count 0, plus sync and output latency.
    function automatic int exp_t(input int nbits);
        return (nbits - 1) * OS + 12;
    endfunction

    task automatic add_frame(input logic [8:0] d, input int nd, input int pen, input logic pbit,
                             input logic [1:0] stp, input int ns);
        logic b[$];
        b.push_back(1'b0);
        for (int i = 0; i < nd; i++) b.push_back(d[i]);
        if (pen != 0) b.push_back(pbit);
        for (int i = 0; i < ns; i++) b.push_back(stp[i]);
        foreach (b[i]) repeat (OS) wave.push_back(b[i]);
    endtask

    task automatic add_idle(input int n);
        repeat (n) wave.push_back(1'b1);
    endtask

    // Play the tick waveform on one line; cpt clocks per ena tick.
    task automatic play(input int sel, input int cpt, output int t0);
        t0 = 0;
        for (int i = 0; i < wave.size(); i++) begin
            for (int j = 0; j < cpt; j++) begin
                @(negedge clk);
                if (i == 0 && j == 0) t0 = ncyc;
                if (j == 0) lines[sel] = wave[i];
                ena = (j == cpt - 1);
            end
        end
        wave.delete();
        ena = 1'b1;
    endtask

    task automatic pop_cap(input int sel, output int n, output cap_t c);
        c = '{d: 9'h000, pe: 1'b0, fe: 1'b0, bk: 1'b0, t: 0};
        case (sel)
            0: begin n = qa.size(); if (n > 0) c = qa.pop_front(); end
            1: begin n = qp.size(); if (n > 0) c = qp.pop_front(); end
            default: begin n = qs.size(); if (n > 0) c = qs.pop_front(); end
        endcase
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ena = 1'b1;
        lines = 3'b111;
        repeat (4) @(negedge clk);
        checks++;
        if ({out_a, valid_a, busy_a, fe_a, pe_a, bk_a} !== 13'd0) begin
            failures++; $display("FAIL reset_a got=%h exp=0", {out_a, valid_a, busy_a, fe_a, pe_a, bk_a});
        end
        checks++;
        if ({out_p, valid_p, busy_p, fe_p, pe_p, bk_p} !== 13'd0) begin
            failures++; $display("FAIL reset_p got=%h exp=0", {out_p, valid_p, busy_p, fe_p, pe_p, bk_p});
        end
        checks++;
        if ({out_s, valid_s, busy_s, fe_s, pe_s, bk_s} !== 12'd0) begin
            failures++; $display("FAIL reset_s got=%h exp=0", {out_s, valid_s, busy_s, fe_s, pe_s, bk_s});
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        qa.delete(); qp.delete(); qs.delete();
    endtask

    task automatic test_8n1();
        int t0, n;
        cap_t c;
        add_frame(9'h0A5, 8, 0, 1'b0, 2'b11, 1);
        add_idle(32);
        play(0, 1, t0);
        pop_cap(0, n, c);
        checks++;
        if (n != 1) begin failures++; $display("FAIL t8n1_count got=%0d exp=1", n); end
        checks++;
        if (c.d !== 9'h0A5) begin failures++; $display("FAIL t8n1_data got=%h exp=0a5", c.d); end
        checks++;
        if ({c.pe, c.fe, c.bk} !== 3'b000) begin failures++; $display("FAIL t8n1_flags got=%b exp=000", {c.pe, c.fe, c.bk}); end
        checks++;
        if (c.t != t0 + 156) begin failures++; $display("FAIL t8n1_latency got=%0d exp=%0d", c.t - t0, 156); end
        checks++;
        if (rise_a < t0 + 3 || rise_a > t0 + 4 || fall_a != t0 + 156) begin
            failures++; $display("FAIL t8n1_busy rise=%0d fall=%0d exp_fall=156", rise_a - t0, fall_a - t0);
        end
    endtask

    task automatic test_false_start();
        int t0;
        repeat (4) wave.push_back(1'b0);
        add_idle(60);
        play(0, 1, t0);
        checks++;
        if (qa.size() != 0) begin failures++; $display("FAIL false_start_valid got=%0d exp=0", qa.size()); end
        checks++;
        if (fall_a != t0 + 12 || busy_a !== 1'b0) begin
            failures++; $display("FAIL false_start_busy fall=%0d exp=12 busy=%b", fall_a - t0, busy_a);
        end
        qa.delete();
    endtask

    task automatic test_parity();
        int t0, n;
        cap_t c;
        add_frame(9'h03C, 8, 1, 1'b1, 2'b11, 1);
        add_idle(32);
        add_frame(9'h03C, 8, 1, 1'b0, 2'b11, 1);
        add_idle(32);
        play(1, 1, t0);
        for (int k = 0; k < 2; k++) begin
            pop_cap(1, n, c);
            checks++;
            if (n == 0 || c.d !== 9'h03C || {c.pe, c.fe, c.bk} !== {(k == 0), 2'b00}) begin
                failures++;
                $display("FAIL parity_%0d n=%0d data=%h flags=%b exp_data=03c exp_pe=%0d", k, n, c.d, {c.pe, c.fe, c.bk}, (k == 0));
            end
        end
    endtask

    task automatic test_frame_break();
        int t0, n;
        cap_t c;
        add_frame(9'h055, 8, 0, 1'b0, 2'b00, 1);
        add_idle(40);
        play(0, 1, t0);
        pop_cap(0, n, c);
        checks++;
        if (n == 0 || c.d !== 9'h055 || {c.pe, c.fe, c.bk} !== 3'b010) begin
            failures++; $display("FAIL frame_err n=%0d data=%h flags=%b exp=055/010", n, c.d, {c.pe, c.fe, c.bk});
        end
        checks++;
        if (fe_a !== 1'b1 || bk_a !== 1'b0) begin
            failures++; $display("FAIL flag_hold fe=%b bk=%b exp=1/0", fe_a, bk_a);
        end
        add_frame(9'h000, 8, 0, 1'b0, 2'b00, 1);
        add_idle(40);
        play(0, 1, t0);
        pop_cap(0, n, c);
        checks++;
        if (n == 0 || c.d !== 9'h000 || {c.pe, c.fe, c.bk} !== 3'b011) begin
            failures++; $display("FAIL break n=%0d data=%h flags=%b exp=000/011", n, c.d, {c.pe, c.fe, c.bk});
        end
        qa.delete();
    endtask

    task automatic test_spike();
        int t0, n;
        cap_t c;
        add_frame(9'h000, 8, 0, 1'b0, 2'b11, 1);
        add_idle(32);
        wave[24] = 1'b1;
        play(0, 1, t0);
        pop_cap(0, n, c);
        checks++;
        if (n != 1 || c.d !== 9'h000 || {c.pe, c.fe, c.bk} !== 3'b000) begin
            failures++; $display("FAIL spike n=%0d data=%h flags=%b exp=1/000/000", n, c.d, {c.pe, c.fe, c.bk});
        end
        qa.delete();
    endtask

    task automatic test_back_to_back();
        int t0, n;
        cap_t c;
        logic [8:0] d3;
        add_frame(9'h012, 7, 0, 1'b0, 2'b11, 2);
        add_frame(9'h06D, 7, 0, 1'b0, 2'b11, 2);
        add_idle(32);
        play(2, 1, t0);
        pop_cap(2, n, c);
        checks++;
        if (n == 0 || c.d !== 9'h012 || c.t != t0 + 156 || {c.pe, c.fe, c.bk} !== 3'b000) begin
            failures++; $display("FAIL b2b_first n=%0d data=%h t=%0d exp=012 t=156", n, c.d, c.t - t0);
        end
        pop_cap(2, n, c);
        checks++;
        if (n == 0 || c.d !== 9'h06D || c.t != t0 + 316 || {c.pe, c.fe, c.bk} !== 3'b000) begin
            failures++; $display("FAIL b2b_second n=%0d data=%h t=%0d exp=06d t=316", n, c.d, c.t - t0);
        end
        d3 = 9'($urandom_range(0, 127));
        add_frame(d3, 7, 0, 1'b0, 2'b11, 2);
        while (wave.size() > 62) void'(wave.pop_back());
        play(2, 1, t0);
        @(negedge clk);
        rst = 1'b1;
        lines[2] = 1'b1;
        @(negedge clk);
        checks++;
        if (busy_s !== 1'b0 || valid_s !== 1'b0) begin
            failures++; $display("FAIL reset_mid busy=%b valid=%b exp=0/0", busy_s, valid_s);
        end
        rst = 1'b0;
        add_idle(200);
        play(2, 1, t0);
        checks++;
        if (qs.size() != 0) begin failures++; $display("FAIL reset_no_valid got=%0d exp=0", qs.size()); end
        qs.delete();
        qa.delete(); qp.delete();
        add_frame(9'h033, 7, 0, 1'b0, 2'b11, 2);
        add_idle(32);
        play(2, 1, t0);
        pop_cap(2, n, c);
        checks++;
        if (n != 1 || c.d !== 9'h033 || {c.pe, c.fe, c.bk} !== 3'b000) begin
            failures++; $display("FAIL after_reset n=%0d data=%h exp=1/033", n, c.d);
        end
    endtask

    task automatic test_random(input int iters, input int cpt);
        int t0, n, sel, nd, pen, ns;
        logic [8:0]  d;
        logic        pbit;
        logic [1:0]  stp;
        logic [2:0]  ef;
        cap_t c;
        for (int it = 0; it < iters; it++) begin
            sel  = (cpt == 1) ? int'($urandom_range(0, 2)) : 0;
            nd   = (sel == 2) ? 7 : 8;
            pen  = (sel == 1) ? 1 : 0;
            ns   = (sel == 2) ? 2 : 1;
            d    = 9'($urandom) & ((9'd1 << nd) - 9'd1);
            pbit = 1'($urandom);
            stp  = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
            ef   = model_flags(d, nd, pen, pbit, stp, ns);
            add_frame(d, nd, pen, pbit, stp, ns);
            add_idle(32);
            play(sel, cpt, t0);
            pop_cap(sel, n, c);
            checks++;
            if (n != 1 || c.d !== d || {c.pe, c.fe, c.bk} !== ef) begin
                failures++;
                $display("FAIL random_%0d sel=%0d n=%0d data=%h exp=%h flags=%b exp=%b", it, sel, n, c.d, d, {c.pe, c.fe, c.bk}, ef);
            end
            if (cpt == 1) begin
                checks++;
                if (c.t != t0 + exp_t(1 + nd + pen + ns)) begin
                    failures++; $display("FAIL random_lat_%0d got=%0d exp=%0d", it, c.t - t0, exp_t(1 + nd + pen + ns));
                end
            end
            qa.delete(); qp.delete(); qs.delete();
        end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_false_start();
        test_parity();
        test_frame_break();
        test_spike();
        test_back_to_back();
        test_random(12, 1);
        test_random(3, 3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
